// File: rtl/posted_write_buffer_pkg.sv
// -----------------------------------------------------------------------------
// posted_write_buffer_pkg
// Shared definitions for the posted write buffer:
//   - entry layout helpers for a queued request {wr_ni, address, dataW}
//   - state encodings for the upstream and downstream handshake FSMs
// -----------------------------------------------------------------------------
package posted_write_buffer_pkg;

    // Queued entry layout, LSB first: dataW, then address, then the write flag.
    localparam int DATA_LSB = 0;

    function automatic int addr_lsb(input int data_width);
        return data_width;
    endfunction

    function automatic int wr_bit(input int addr_width, input int data_width);
        return addr_width + data_width;
    endfunction

    function automatic int entry_width(input int addr_width, input int data_width);
        return 1 + addr_width + data_width;
    endfunction

    // Upstream side: accept, acknowledge, or wait for a blocking read to retire.
    typedef enum logic [1:0] {
        UP_IDLE    = 2'd0,
        UP_ACK     = 2'd1,
        UP_RD_WAIT = 2'd2
    } up_state_t;

    // Downstream side: issue the head entry, then wait for the ram acknowledge.
    typedef enum logic {
        DN_IDLE = 1'b0,
        DN_WAIT = 1'b1
    } dn_state_t;

endpackage

// File: rtl/posted_write_buffer_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with wrap-around pointers and an occupancy counter.
// The head entry is presented combinationally on dout so the consumer can
// load it in the same cycle it sees empty=0.
// Ports:
//   clk, reset (synchronous, active low)
//   push/din  : enqueue; accepted when not full, or when a pop happens too
//   pop/dout  : dequeue head; ignored when empty
//   full, empty, count (0..DEPTH)
// -----------------------------------------------------------------------------
module sync_fifo #(
    parameter int WIDTH     = 13,
    parameter int DEPTH     = 4,
    parameter int PTR_WIDTH = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 push,
    input  logic                 pop,
    input  logic [WIDTH-1:0]     din,
    output logic [WIDTH-1:0]     dout,
    output logic                 full,
    output logic                 empty,
    output logic [PTR_WIDTH:0]   count
);

    localparam logic [PTR_WIDTH:0] FULL_COUNT = (PTR_WIDTH+1)'(DEPTH);

    logic [WIDTH-1:0]     mem [DEPTH];
    logic [PTR_WIDTH-1:0] wr_ptr_reg;
    logic [PTR_WIDTH-1:0] rd_ptr_reg;
    logic [PTR_WIDTH:0]   count_reg;
    logic                 do_push;
    logic                 do_pop;

    assign empty = (count_reg == '0);
    assign full  = (count_reg == FULL_COUNT);
    assign count = count_reg;
    assign dout  = mem[rd_ptr_reg];

    // A full FIFO can still take a push when the head leaves in the same cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + PTR_WIDTH'(1);
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PTR_WIDTH'(1);
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + (PTR_WIDTH+1)'(1);
                2'b01:   count_reg <= count_reg - (PTR_WIDTH+1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Storage carries no reset; validity is tracked by the pointers alone.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_reg] <= din;
    end

endmodule

// File: rtl/posted_write_buffer.sv
// -----------------------------------------------------------------------------
// posted_write_buffer
// Request buffer between the arbiter server port (up_*) and the ram (dn_*).
// Writes are acknowledged as soon as they are queued; reads are queued behind
// all earlier writes and acknowledged only once the ram has returned data.
// Ports:
//   clk, reset (synchronous, active low)
//   up_rq/up_ack/up_wr_ni/up_address/up_dataW/up_dataR : arbiter side
//   dn_rq/dn_ack/dn_wr_ni/dn_address/dn_dataW/dn_dataR : ram side
//   level : FIFO occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module posted_write_buffer
    import posted_write_buffer_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int DEPTH      = 4,
    parameter int PTR_WIDTH  = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] up_address,
    input  logic                  up_rq,
    output logic                  up_ack,
    input  logic                  up_wr_ni,
    input  logic [DATA_WIDTH-1:0] up_dataW,
    output logic [DATA_WIDTH-1:0] up_dataR,
    output logic [ADDR_WIDTH-1:0] dn_address,
    output logic                  dn_rq,
    input  logic                  dn_ack,
    output logic                  dn_wr_ni,
    output logic [DATA_WIDTH-1:0] dn_dataW,
    input  logic [DATA_WIDTH-1:0] dn_dataR,
    output logic [PTR_WIDTH:0]    level
);

    localparam int ENTRY_WIDTH = entry_width(ADDR_WIDTH, DATA_WIDTH);
    localparam int WR_BIT      = wr_bit(ADDR_WIDTH, DATA_WIDTH);
    localparam int ADDR_LSB    = addr_lsb(DATA_WIDTH);

    logic                   fifo_push;
    logic                   fifo_pop;
    logic [ENTRY_WIDTH-1:0] fifo_din;
    logic [ENTRY_WIDTH-1:0] fifo_dout;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [PTR_WIDTH:0]     fifo_count;

    up_state_t              up_state_reg, up_state_next;
    dn_state_t              dn_state_reg, dn_state_next;
    logic [DATA_WIDTH-1:0]  up_dataR_reg, up_dataR_next;
    logic                   dn_rq_reg, dn_rq_next;
    logic                   dn_wr_ni_reg, dn_wr_ni_next;
    logic [ADDR_WIDTH-1:0]  dn_address_reg, dn_address_next;
    logic [DATA_WIDTH-1:0]  dn_dataW_reg, dn_dataW_next;
    logic                   rd_done;

    sync_fifo #(
        .WIDTH     (ENTRY_WIDTH),
        .DEPTH     (DEPTH),
        .PTR_WIDTH (PTR_WIDTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (fifo_din),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign fifo_din = {up_wr_ni, up_address, up_dataW};

    // The head is still visible while it is being popped, so its type tells
    // whether the retiring transaction is the outstanding read.
    assign rd_done = fifo_pop && !fifo_dout[WR_BIT];

    // Upstream FSM
    always_comb begin
        up_state_next = up_state_reg;
        up_dataR_next = up_dataR_reg;
        fifo_push     = 1'b0;
        case (up_state_reg)
            UP_IDLE: begin
                if (up_rq && (!fifo_full || fifo_pop)) begin
                    fifo_push     = 1'b1;
                    up_state_next = up_wr_ni ? UP_ACK : UP_RD_WAIT;
                end
            end
            UP_ACK: begin
                up_state_next = UP_IDLE;
            end
            UP_RD_WAIT: begin
                if (rd_done) begin
                    up_dataR_next = dn_dataR;
                    up_state_next = UP_ACK;
                end
            end
            default: up_state_next = UP_IDLE;
        endcase
    end

    // Downstream FSM
    always_comb begin
        dn_state_next   = dn_state_reg;
        dn_rq_next      = dn_rq_reg;
        dn_wr_ni_next   = dn_wr_ni_reg;
        dn_address_next = dn_address_reg;
        dn_dataW_next   = dn_dataW_reg;
        fifo_pop        = 1'b0;
        case (dn_state_reg)
            DN_IDLE: begin
                if (!fifo_empty) begin
                    dn_wr_ni_next   = fifo_dout[WR_BIT];
                    dn_address_next = fifo_dout[ADDR_LSB +: ADDR_WIDTH];
                    dn_dataW_next   = fifo_dout[DATA_LSB +: DATA_WIDTH];
                    dn_rq_next      = 1'b1;
                    dn_state_next   = DN_WAIT;
                end
            end
            DN_WAIT: begin
                if (dn_ack) begin
                    fifo_pop      = 1'b1;
                    dn_rq_next    = 1'b0;
                    dn_state_next = DN_IDLE;
                end
            end
            default: dn_state_next = DN_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            up_state_reg   <= UP_IDLE;
            dn_state_reg   <= DN_IDLE;
            up_dataR_reg   <= '0;
            dn_rq_reg      <= 1'b0;
            dn_wr_ni_reg   <= 1'b0;
            dn_address_reg <= '0;
            dn_dataW_reg   <= '0;
        end else begin
            up_state_reg   <= up_state_next;
            dn_state_reg   <= dn_state_next;
            up_dataR_reg   <= up_dataR_next;
            dn_rq_reg      <= dn_rq_next;
            dn_wr_ni_reg   <= dn_wr_ni_next;
            dn_address_reg <= dn_address_next;
            dn_dataW_reg   <= dn_dataW_next;
        end
    end

    assign up_ack     = (up_state_reg == UP_ACK);
    assign up_dataR   = up_dataR_reg;
    assign dn_rq      = dn_rq_reg;
    assign dn_wr_ni   = dn_wr_ni_reg;
    assign dn_address = dn_address_reg;
    assign dn_dataW   = dn_dataW_reg;
    assign level      = fifo_count;

endmodule

// File: tb/tb_posted_write_buffer.sv
// -----------------------------------------------------------------------------
// tb_posted_write_buffer
// Directed bench for posted_write_buffer with a behavioural ram on the dn side
// whose acknowledge delay is programmable per test.
// -----------------------------------------------------------------------------
module tb_posted_write_buffer;

    localparam int DW = 8;
    localparam int AW = 4;
    localparam int DEPTH = 4;
    localparam int PW = 2;

    logic          clk;
    logic          reset;
    logic [AW-1:0] up_address;
    logic          up_rq;
    logic          up_ack;
    logic          up_wr_ni;
    logic [DW-1:0] up_dataW;
    logic [DW-1:0] up_dataR;
    logic [AW-1:0] dn_address;
    logic          dn_rq;
    logic          dn_ack;
    logic          dn_wr_ni;
    logic [DW-1:0] dn_dataW;
    logic [DW-1:0] dn_dataR;
    logic [PW:0]   level;

    posted_write_buffer #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .DEPTH      (DEPTH),
        .PTR_WIDTH  (PW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .up_address (up_address),
        .up_rq      (up_rq),
        .up_ack     (up_ack),
        .up_wr_ni   (up_wr_ni),
        .up_dataW   (up_dataW),
        .up_dataR   (up_dataR),
        .dn_address (dn_address),
        .dn_rq      (dn_rq),
        .dn_ack     (dn_ack),
        .dn_wr_ni   (dn_wr_ni),
        .dn_dataW   (dn_dataW),
        .dn_dataR   (dn_dataR),
        .level      (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;

    // ---------------- behavioural ram ----------------
    logic [DW-1:0] ram_mem [16];
    int            ram_delay = 1;
    int            wait_cnt = 0;
    logic [AW-1:0] log_addr [$];
    logic [DW-1:0] log_data [$];
    logic          log_wr   [$];

    always @(posedge clk) begin
        #1;
        if (!reset) begin
            dn_ack   = 1'b0;
            wait_cnt = 0;
        end else if (dn_ack) begin
            dn_ack = 1'b0;
        end else if (dn_rq) begin
            if (wait_cnt >= ram_delay) begin
                if (dn_wr_ni) ram_mem[dn_address] = dn_dataW;
                dn_dataR = ram_mem[dn_address];
                dn_ack   = 1'b1;
                wait_cnt = 0;
                log_addr.push_back(dn_address);
                log_data.push_back(dn_dataW);
                log_wr.push_back(dn_wr_ni);
            end else begin
                wait_cnt++;
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_log();
        log_addr.delete();
        log_data.delete();
        log_wr.delete();
    endtask

    // Issue one upstream request and wait (bounded) for its acknowledge.
    task automatic do_req(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          output int lat, output int log_at_ack);
        @(posedge clk);
        #1;
        up_rq      = 1'b1;
        up_wr_ni   = wr;
        up_address = a;
        up_dataW   = d;
        lat        = 0;
        while (1) begin
            @(posedge clk);
            #1;
            lat++;
            if (up_ack === 1'b1 || lat >= 200) break;
        end
        log_at_ack = log_addr.size();
        up_rq = 1'b0;
        check("ack_received", {31'd0, up_ack}, 32'd1);
        $display("%s addr=%0h wdata=%0h ack_latency=%0d rdata=%0h level=%0d",
                 wr ? "WR" : "RD", a, d, lat, up_dataR, level);
    endtask

    task automatic wait_drain();
        int  cyc = 0;
        while (!(level == 0 && !dn_rq && !up_ack) && cyc < 500) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("drain_done", {31'd0, (cyc < 500)}, 32'd1);
    endtask

    // ---------------- vectors ----------------
    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        int            delay;
        int            max_lat;
        logic [DW-1:0] exp_r;
    } vec_t;

    vec_t vecs [8];

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int lat;
        int la;
        int spurious;
        logic [AW-1:0] exp_a [5];
        logic [DW-1:0] exp_d [5];

        vecs[0] = '{1'b1, 4'h3, 8'hA5, 1, 1, 8'h00};
        vecs[1] = '{1'b1, 4'h5, 8'h3C, 2, 1, 8'h00};
        vecs[2] = '{1'b0, 4'h5, 8'h00, 1, 6, 8'h3C};
        vecs[3] = '{1'b0, 4'h9, 8'h00, 0, 4, 8'h7E};
        vecs[4] = '{1'b1, 4'h9, 8'h11, 0, 1, 8'h00};
        vecs[5] = '{1'b0, 4'h9, 8'h00, 3, 8, 8'h11};
        vecs[6] = '{1'b1, 4'hF, 8'hFF, 1, 1, 8'h00};
        vecs[7] = '{1'b0, 4'h3, 8'h00, 1, 6, 8'hA5};

        exp_a = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h6};
        exp_d = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h60};

        for (int i = 0; i < 16; i++) ram_mem[i] = 8'h00;
        ram_mem[9] = 8'h7E;

        reset = 1'b0; up_rq = 1'b0; up_wr_ni = 1'b0; up_address = '0;
        up_dataW = '0; dn_ack = 1'b0; dn_dataR = '0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_up_ack",     {31'd0, up_ack},   32'd0);
        check("rst_up_dataR",   {24'd0, up_dataR}, 32'd0);
        check("rst_dn_rq",      {31'd0, dn_rq},    32'd0);
        check("rst_dn_address", {28'd0, dn_address}, 32'd0);
        check("rst_dn_wr_ni",   {31'd0, dn_wr_ni}, 32'd0);
        check("rst_dn_dataW",   {24'd0, dn_dataW}, 32'd0);
        check("rst_level",      {29'd0, level},    32'd0);
        reset = 1'b1;

        // Table-driven single transactions, each drained before the next.
        for (int i = 0; i < 8; i++) begin
            clear_log();
            ram_delay = vecs[i].delay;
            do_req(vecs[i].wr, vecs[i].addr, vecs[i].data, lat, la);
            check($sformatf("vec%0d_latency_ok", i), {31'd0, (lat <= vecs[i].max_lat)}, 32'd1);
            if (!vecs[i].wr)
                check($sformatf("vec%0d_rdata", i), {24'd0, up_dataR}, {24'd0, vecs[i].exp_r});
            wait_drain();
            check($sformatf("vec%0d_dn_count", i), log_addr.size(), 32'd1);
            if (log_addr.size() == 1) begin
                check($sformatf("vec%0d_dn_addr", i), {28'd0, log_addr[0]}, {28'd0, vecs[i].addr});
                check($sformatf("vec%0d_dn_wr", i), {31'd0, log_wr[0]}, {31'd0, vecs[i].wr});
                if (vecs[i].wr)
                    check($sformatf("vec%0d_dn_data", i), {24'd0, log_data[0]}, {24'd0, vecs[i].data});
            end
            check($sformatf("vec%0d_level", i), {29'd0, level}, 32'd0);
        end

        // Read after write: the read must reach the ram only after the write.
        clear_log();
        ram_delay = 3;
        do_req(1'b1, 4'h5, 8'hC3, lat, la);
        check("raw_wr_latency", lat, 32'd1);
        do_req(1'b0, 4'h5, 8'h00, lat, la);
        check("raw_rdata", {24'd0, up_dataR}, 32'hC3);
        wait_drain();
        check("raw_dn_count", log_addr.size(), 32'd2);
        if (log_addr.size() == 2) begin
            check("raw_first_is_write", {31'd0, log_wr[0]}, 32'd1);
            check("raw_second_is_read", {31'd0, log_wr[1]}, 32'd0);
            check("raw_second_addr", {28'd0, log_addr[1]}, 32'h5);
        end

        // Fill the FIFO behind a slow ram; the fifth write is accepted in the
        // same cycle the first entry pops.
        clear_log();
        ram_delay = 10;
        for (int i = 0; i < 4; i++) begin
            do_req(1'b1, exp_a[i], exp_d[i], lat, la);
            check($sformatf("full_wr%0d_latency", i), lat, 32'd1);
        end
        check("full_level", {29'd0, level}, 32'd4);
        do_req(1'b1, exp_a[4], exp_d[4], lat, la);
        check("full_wr4_stalled", {31'd0, (lat > 1)}, 32'd1);
        check("full_wr4_after_first_pop", la, 32'd1);
        check("full_level_after_push_pop", {29'd0, level}, 32'd4);
        ram_delay = 0;
        wait_drain();
        check("full_dn_count", log_addr.size(), 32'd5);
        if (log_addr.size() == 5) begin
            for (int i = 0; i < 5; i++) begin
                check($sformatf("full_order%0d_addr", i), {28'd0, log_addr[i]}, {28'd0, exp_a[i]});
                check($sformatf("full_order%0d_data", i), {24'd0, log_data[i]}, {24'd0, exp_d[i]});
            end
        end

        // Reset while the ram is holding off an acknowledge with two entries queued.
        clear_log();
        ram_delay = 50;
        do_req(1'b1, 4'hA, 8'h55, lat, la);
        do_req(1'b1, 4'hB, 8'h66, lat, la);
        check("rstmid_level_before", {29'd0, level}, 32'd2);
        check("rstmid_dn_rq_before", {31'd0, dn_rq}, 32'd1);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("rstmid_dn_rq", {31'd0, dn_rq}, 32'd0);
        check("rstmid_level", {29'd0, level}, 32'd0);
        check("rstmid_up_ack", {31'd0, up_ack}, 32'd0);
        check("rstmid_up_dataR", {24'd0, up_dataR}, 32'd0);
        reset = 1'b1;
        spurious = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            if (up_ack || dn_rq) spurious++;
        end
        check("rstmid_no_spurious", spurious, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/posted_write_buffer.md
Name: posted_write_buffer

Overview:
- Request buffer between the bus_arbiter server port and the ram.
- Writes are posted: acknowledged upstream as soon as they are queued.
- Reads are blocking: they wait behind all queued writes so read-after-write order is preserved, then return ram data upstream.
- Both sides use the codebase rq/ack handshake; the block decouples arbiter throughput from ram latency.

Parameters:
- DATA_WIDTH, 8, data bus width
- ADDR_WIDTH, 4, address width
- DEPTH, 4, FIFO entries; power of two, ≥2
- PTR_WIDTH, 2, log2(DEPTH)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-low reset
- up_address  in  ADDR_WIDTH  request address from arbiter
- up_rq  in  1  request from arbiter, held until up_ack
- up_ack  out  1  one-cycle acknowledge to arbiter
- up_wr_ni  in  1  1 = write, 0 = read
- up_dataW  in  DATA_WIDTH  write data
- up_dataR  out  DATA_WIDTH  read data, valid while up_ack=1 for a read
- dn_address  out  ADDR_WIDTH  address to ram
- dn_rq  out  1  request to ram
- dn_ack  in  1  ram acknowledge
- dn_wr_ni  out  1  write/read to ram
- dn_dataW  out  DATA_WIDTH  write data to ram
- dn_dataR  in  DATA_WIDTH  read data from ram
- level  out  PTR_WIDTH+1  current FIFO occupancy, 0..DEPTH

Behaviour:
- Handshake, both sides: requester holds rq and all fields stable until ack is high; ack is a single-cycle pulse. rq high in the cycle after ack counts as a new request.
- Reset (reset=0 at a clk edge):
  - up_ack=0, up_dataR=0, dn_rq=0, dn_address=0, dn_wr_ni=0, dn_dataW=0, level=0.
  - FIFO emptied; both FSMs return to IDLE.
  - Reset mid-transaction abandons it: dn_rq drops next edge, and no late up_ack is issued.
- FIFO entry: {wr_ni, address, dataW}. Wrap-around pointers, PTR_WIDTH+1 bit count; full is count==DEPTH.
- Upstream FSM:
  - UP_IDLE:
    - up_rq=1, up_wr_ni=1, not full: push entry; go to UP_ACK.
    - up_rq=1, up_wr_ni=1, full: stall in UP_IDLE, no ack.
    - up_rq=1, up_wr_ni=0: push read entry (not full required); go to UP_RD_WAIT.
  - UP_ACK: up_ack=1 for exactly one cycle; up_rq is not sampled this cycle; go to UP_IDLE. Write latency is rq→ack = 1 cycle when not full.
  - UP_RD_WAIT: no new requests accepted. When the downstream side retires the read entry, register dn_dataR into up_dataR and pulse up_ack the following cycle; go to UP_IDLE. up_dataR holds until the next read completes.
- Downstream FSM:
  - DN_IDLE: if not empty, load head entry onto dn_* registers, set dn_rq=1; go to DN_WAIT.
  - DN_WAIT: hold dn_rq and fields. On dn_ack=1: pop, dn_rq=0 next cycle, go to DN_IDLE. If the popped entry is a read, flag read-done to the upstream FSM.
  - Minimum 2 cycles per downstream transaction: one idle cycle between transactions.
- Simultaneous push and pop in one cycle: count unchanged and pointers both advance. A push to a full FIFO is legal in the same cycle as a pop.
- Ordering: strictly FIFO; a read never bypasses earlier writes.
- Only one read is ever outstanding.

Decomposition:
- Package posted_write_buffer_pkg:
  - entry field offsets WR_BIT, ADDR_LSB, DATA_LSB, ENTRY_WIDTH = 1+ADDR_WIDTH+DATA_WIDTH
  - up-FSM state constants UP_IDLE/UP_ACK/UP_RD_WAIT
  - dn-FSM state constants DN_IDLE/DN_WAIT
- Sub-module sync_fifo (params WIDTH, DEPTH, PTR_WIDTH; ports clk, reset, push, pop, din, dout, full, empty, count): storage and pointers. Both FSMs stay in the top.

Test Plan:
- Single write, ram ack after 1 cycle: addr 4'h3, dataW 8'hA5 → up_ack 1 cycle after rq; dn_rq with addr 3/A5 next; level returns 0.
- Four back-to-back writes with ram ack delayed 10 cycles → each acked upstream within 1 cycle; level reaches 3–4. A fifth write stalls with no up_ack until the first dn_ack.
- Write addr 5 = 8'h3C then read addr 5 → the read's dn_rq follows the write's dn_ack; up_dataR=8'h3C with up_ack.
- FIFO full (4 entries) while dn_ack pops and a new write arrives in the same cycle → level stays 4; entry order in dn_address matches issue order.
- Reset asserted while in DN_WAIT with level=2 → next cycle dn_rq=0, level=0, up_ack=0; no spurious ack afterwards.
- Read to empty buffer, ram ack immediate with dn_dataR 8'h7E → up_ack at most 4 cycles after up_rq; up_dataR=8'h7E.
